// File: rtl/radix_seg_converter.sv
// Sequential binary to seven-segment converter: one restoring-division digit per WIDTH+1 cycles,
// selectable octal/decimal/hex radix, optional leading-zero blanking and overflow dashes.
module radix_seg_converter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [1:0]            in_mode,
  output logic [7*DIGITS-1:0]   seg_out,
  output logic                  out_valid,
  output logic                  overflow,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StDiv, StStore, StDone} state_e;

  localparam logic [6:0] GlyphDash = 7'b0000001;

  state_e                r_state;
  state_e                w_state_next;
  logic [WIDTH-1:0]      r_q;
  logic [4:0]            r_rem;
  logic [4:0]            r_radix;
  logic [5:0]            r_cnt;
  logic [3:0]            r_k;
  logic                  r_reserved;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [7*DIGITS-1:0]   r_seg;
  logic                  r_out_valid;
  logic                  r_overflow;

  logic                  w_accept;
  logic                  w_last_bit;
  logic                  w_last_digit;
  logic [5:0]            w_rem_sh;
  logic                  w_ge;
  logic                  w_ovf;
  logic [7*DIGITS-1:0]   w_seg_next;

  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    logic [6:0] g;
    g = 7'b0000000;
    case (d)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
    endcase
    return g;
  endfunction

  assign w_accept     = in_valid & in_ready;
  assign w_last_bit   = (r_cnt == 6'(WIDTH - 1));
  assign w_last_digit = (r_k == 4'(DIGITS - 1));
  // Remainder stays below the radix, so the shifted value always fits in six bits.
  assign w_rem_sh     = {r_rem, r_q[WIDTH-1]};
  assign w_ge         = (w_rem_sh >= {1'b0, r_radix});
  assign w_ovf        = ~r_reserved & (r_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = (in_mode == 2'b11) ? StDone : StDiv;
      StDiv:   if (w_last_bit) w_state_next = StStore;
      StStore: w_state_next = w_last_digit ? StDone : StDiv;
      StDone:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == StIdle);
    busy      = (r_state != StIdle);
    out_valid = r_out_valid;
    seg_out   = r_seg;
    overflow  = r_overflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_rem       <= '0;
      r_radix     <= 5'd8;
      r_cnt       <= '0;
      r_k         <= '0;
      r_reserved  <= 1'b0;
      r_shadow    <= '0;
      r_seg       <= '1;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= (r_state == StDone);
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_q        <= in_data;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_k        <= '0;
            r_reserved <= (in_mode == 2'b11);
            case (in_mode)
              2'b01:   r_radix <= 5'd10;
              2'b10:   r_radix <= 5'd16;
              default: r_radix <= 5'd8;
            endcase
          end
        end
        StDiv: begin
          // Quotient bits shift in at the LSB; after WIDTH steps r_q holds Q / R.
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_rem <= w_ge ? 5'(w_rem_sh - {1'b0, r_radix}) : w_rem_sh[4:0];
          r_cnt <= r_cnt + 6'd1;
        end
        StStore: begin
          r_shadow[4*r_k +: 4] <= r_rem[3:0];
          r_k                  <= r_k + 4'd1;
          r_cnt                <= '0;
          r_rem                <= '0;
        end
        StDone: begin
          r_seg      <= w_seg_next;
          r_overflow <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  always_comb begin : p_blank
    logic       seen;
    logic [3:0] dig;
    logic [6:0] glyph;
    w_seg_next = '0;
    seen       = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      dig   = r_shadow[4*i +: 4];
      // Digit 0 is always shown so a zero value still displays "0".
      seen  = seen | (dig != 4'd0) | (i == 0);
      if (r_reserved || w_ovf) begin
        glyph = GlyphDash;
      end else if ((BLANK_LZ != 0) && !seen) begin
        glyph = 7'b0000000;
      end else begin
        glyph = f_glyph(dig);
      end
      w_seg_next[7*i +: 7] = ~glyph;
    end
  end

endmodule

// File: tb/tb_radix_seg_converter.sv
// Bench for radix_seg_converter: three configurations driven in lockstep, checked every cycle
// against an arithmetic digit model, with literal display patterns pinning the model.
module tb_radix_seg_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic [41:0] seg0, seg1;
  logic [27:0] seg2;
  logic [2:0]  rdy, bsy, ovv, ovf;
  logic [69:0] seg_a [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Monitor-owned expectations
  logic        pend [3];
  int          acc [3];
  int          lat [3];
  logic [69:0] e_seg [3];
  logic        e_ov [3];
  logic [69:0] last_seg [3];
  logic        last_ov [3];
  logic        c_len [3];
  logic [69:0] c_lseg [3];
  logic        c_lov [3];

  // Driver-owned literal expectations for the next request
  logic        l_en [3];
  logic [69:0] l_seg [3];
  logic        l_ov [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  radix_seg_converter #(.WIDTH(16), .DIGITS(6), .BLANK_LZ(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .in_mode(in_mode), .seg_out(seg0), .out_valid(ovv[0]), .overflow(ovf[0]), .busy(bsy[0])
  );
  radix_seg_converter #(.WIDTH(16), .DIGITS(6), .BLANK_LZ(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .in_mode(in_mode), .seg_out(seg1), .out_valid(ovv[1]), .overflow(ovf[1]), .busy(bsy[1])
  );
  radix_seg_converter #(.WIDTH(16), .DIGITS(4), .BLANK_LZ(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
    .in_mode(in_mode), .seg_out(seg2), .out_valid(ovv[2]), .overflow(ovf[2]), .busy(bsy[2])
  );

  assign seg_a[0] = {28'b0, seg0};
  assign seg_a[1] = {28'b0, seg1};
  assign seg_a[2] = {42'b0, seg2};

  function automatic int ndig(input int j);
    return (j == 2) ? 4 : 6;
  endfunction

  function automatic bit blz(input int j);
    return j != 1;
  endfunction

  function automatic logic [69:0] rst_mask(input int nd);
    logic [69:0] r;
    r = '0;
    for (int i = 0; i < 7 * nd; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] glyph_hi(input int v);
    logic [6:0] g;
    case (v)
      0: g = 7'b1111110;  1: g = 7'b0110000;  2: g = 7'b1101101;  3: g = 7'b1111001;
      4: g = 7'b0110011;  5: g = 7'b1011011;  6: g = 7'b1011111;  7: g = 7'b1110000;
      8: g = 7'b1111111;  9: g = 7'b1111011; 10: g = 7'b1110111; 11: g = 7'b0011111;
     12: g = 7'b1001110; 13: g = 7'b0111101; 14: g = 7'b1001111; default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  // Digits by repeated division; whatever is left after nd digits means overflow.
  function automatic void model(input logic [15:0] d, input logic [1:0] m, input int nd,
                                input bit bl, output logic [69:0] seg, output logic ov);
    int base;
    int v;
    int top;
    int dg [10];
    seg = '0;
    ov  = 1'b0;
    if (m == 2'd3) begin
      for (int i = 0; i < nd; i++) seg[7*i +: 7] = 7'b1111110;
      return;
    end
    base = (m == 2'd0) ? 8 : (m == 2'd1) ? 10 : 16;
    v    = int'(d);
    top  = 0;
    for (int i = 0; i < nd; i++) begin
      dg[i] = v % base;
      v     = v / base;
      if (dg[i] != 0) top = i;
    end
    ov = (v != 0);
    for (int i = 0; i < nd; i++) begin
      if (ov)                seg[7*i +: 7] = 7'b1111110;
      else if (bl && i > top) seg[7*i +: 7] = 7'b1111111;
      else                   seg[7*i +: 7] = ~glyph_hi(dg[i]);
    end
  endfunction

  task automatic check_vec(input string nm, input int j, input logic [69:0] act,
                           input logic [69:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", nm, j, cyc, act, exp);
    end
  endtask

  task automatic check_bit(input string nm, input int j, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @cyc %0d: got %b expected %b", nm, j, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (!rst_n) begin
        check_vec("reset_seg", j, seg_a[j], rst_mask(ndig(j)));
        check_bit("reset_ovf", j, ovf[j], 1'b0);
        check_bit("reset_valid", j, ovv[j], 1'b0);
        check_bit("reset_ready", j, rdy[j], 1'b1);
        pend[j]     = 1'b0;
        c_len[j]    = 1'b0;
        last_seg[j] = rst_mask(ndig(j));
        last_ov[j]  = 1'b0;
      end else begin
        logic exp_v;
        exp_v = pend[j] && ((cyc - acc[j]) == lat[j]);
        check_bit("out_valid", j, ovv[j], exp_v);
        if (exp_v) begin
          check_vec("seg_out", j, seg_a[j], e_seg[j]);
          check_bit("overflow", j, ovf[j], e_ov[j]);
          if (c_len[j]) begin
            check_vec("model_pin_seg", j, e_seg[j], c_lseg[j]);
            check_bit("model_pin_ovf", j, e_ov[j], c_lov[j]);
            check_vec("literal_seg", j, seg_a[j], c_lseg[j]);
          end
          last_seg[j] = e_seg[j];
          last_ov[j]  = e_ov[j];
          pend[j]     = 1'b0;
        end else begin
          check_vec("hold_seg", j, seg_a[j], last_seg[j]);
          check_bit("hold_ovf", j, ovf[j], last_ov[j]);
        end
        check_bit("in_ready", j, rdy[j], !pend[j]);
        check_bit("busy", j, bsy[j], pend[j]);
        if (in_valid && !pend[j]) begin
          model(in_data, in_mode, ndig(j), blz(j), e_seg[j], e_ov[j]);
          pend[j]   = 1'b1;
          acc[j]    = cyc + 1;
          lat[j]    = (in_mode == 2'd3) ? 1 : ndig(j) * (16 + 1) + 1;
          c_len[j]  = l_en[j];
          c_lseg[j] = l_seg[j];
          c_lov[j]  = l_ov[j];
        end
      end
    end
  end

  task automatic wait_ready();
    for (int t = 0; t < 300; t++) begin
      if (&rdy) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input int j, input logic [69:0] s, input logic o);
    l_en[j]  = 1'b1;
    l_seg[j] = s;
    l_ov[j]  = o;
  endtask

  task automatic req(input logic [15:0] d, input logic [1:0] m);
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_mode  = 2'($urandom);
    for (int j = 0; j < 3; j++) l_en[j] = 1'b0;
  endtask

  task automatic pulse_busy();
    repeat (10) @(posedge clk);
    #1;
    if (!(|rdy)) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_mode  = 2'($urandom);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin
      l_en[j]  = 1'b0;
      l_seg[j] = '0;
      l_ov[j]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    lit(0, {{3{7'h7F}}, {3{7'b0001111}}}, 1'b0);
    lit(1, {{3{7'b0000001}}, {3{7'b0001111}}}, 1'b0);
    lit(2, {7'h7F, {3{7'b0001111}}}, 1'b0);
    req(16'd511, 2'b00);
    wait_ready();

    lit(0, {7'h7F, 7'b0100000, 7'b0100100, 7'b0100100, 7'b0000110, 7'b0100100}, 1'b0);
    lit(2, {4{7'b1111110}}, 1'b1);
    req(16'd65535, 2'b01);
    wait_ready();

    lit(0, {7'h7F, 7'h7F, 7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000}, 1'b0);
    lit(2, {7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000}, 1'b0);
    req(16'hBEEF, 2'b10);
    wait_ready();

    for (int m = 0; m < 3; m++) begin
      lit(0, {{5{7'h7F}}, 7'b0000001}, 1'b0);
      lit(1, {6{7'b0000001}}, 1'b0);
      lit(2, {{3{7'h7F}}, 7'b0000001}, 1'b0);
      req(16'd0, 2'(m));
      wait_ready();
    end

    lit(2, {4{7'b1111110}}, 1'b1);
    req(16'd12345, 2'b01);
    wait_ready();
    lit(2, {4{7'b0000100}}, 1'b0);
    req(16'd9999, 2'b01);
    wait_ready();

    lit(0, {6{7'b1111110}}, 1'b0);
    lit(1, {6{7'b1111110}}, 1'b0);
    lit(2, {4{7'b1111110}}, 1'b0);
    req(16'd4242, 2'b11);
    wait_ready();

    req(16'd1234, 2'b01);
    pulse_busy();
    pulse_busy();
    wait_ready();

    // Abort mid-conversion, then a clean conversion must follow.
    req(16'd4321, 2'b01);
    repeat (49) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    lit(0, {7'h7F, 7'h7F, 7'b1001111, 7'b1001100, 7'b1001111, 7'b1001111}, 1'b0);
    req(16'd777, 2'b00);
    wait_ready();

    for (int n = 0; n < 25; n++) begin
      req(16'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) pulse_busy();
      wait_ready();
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
